wired_lsu_req_arb: RTL
======================

# wired_lsu_req_arb

Shares the single data-cache request/response port between two requesters: source 0, the in-order LSU issue queue (flushable), and source 1, the committed-store / cache-maintenance path (never flushed). Round-robin arbitration feeds a one-entry output register. An in-order outstanding FIFO routes each response back to the source that issued it. On `flush_i`, in-flight source-0 transactions are tagged so their responses are silently dropped.

## Interface
- `MAX_OUTST`, default 4: number of outstanding downstream requests; must be a power of 2, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: backend flush; kills source-0 traffic.
- `req_valid_i` in [1:0]: per-source request valid.
- `req_ready_o` out [1:0]: per-source request accept.
- `req_i` in `iq_lsu_req_t` [1:0]: per-source request payload.
- `resp_valid_o` out [1:0]: per-source response valid.
- `resp_ready_i` in [1:0]: per-source response ready.
- `resp_o` out `iq_lsu_resp_t`: response payload, broadcast to both sources.
- `m_req_valid_o` out 1: downstream request valid.
- `m_req_ready_i` in 1: downstream request ready.
- `m_req_o` out `iq_lsu_req_t`: downstream request payload, registered.
- `m_resp_valid_i` in 1: downstream response valid; responses return in request order.
- `m_resp_ready_o` out 1: downstream response ready.
- `m_resp_i` in `iq_lsu_resp_t`: downstream response payload.

## Operation
- State:
  - output register `out_valid_q`, `out_src_q`, `out_req_q`;
  - round-robin pointer `rr_q` (1 bit, the favoured source);
  - outstanding FIFO of `MAX_OUTST` entries {src, discard}, with head, tail and count;
  - `full` = count == `MAX_OUTST`.
- Reset: `out_valid_q`=0, `rr_q`=0, FIFO empty. Resulting outputs: `m_req_valid_o`=0, `resp_valid_o`=00, `m_resp_ready_o`=0, `req_ready_o`=11 (no flush asserted).
- Load enable: `ld` = !`out_valid_q` | (`m_req_valid_o` & `m_req_ready_i`).
- Eligibility: source 0 is eligible iff `req_valid_i[0]` & !`flush_i`; source 1 iff `req_valid_i[1]`.
- Grant:
  - one eligible source wins;
  - both eligible: `rr_q` wins.
- `req_ready_o[k]` = `ld` & (no eligible source other than k, or k == `rr_q`). For source 0 it additionally requires !`flush_i`.
- Handshake on source k: load the output register with `req_i[k]` and k, then set `rr_q` to !k. With no handshake and `ld`=1, `out_valid_q` becomes 0.
- `m_req_valid_o` = `out_valid_q` & !`full`. `m_req_o` = `out_req_q`, held stable until accepted.
- Downstream request handshake: push {`out_src_q`, `flush_i` & (`out_src_q`==0)} into the FIFO.
- Flush handling:
  - if the output register holds an unaccepted source-0 request, clear `out_valid_q` (downstream is flushed by the same `flush_i`);
  - every FIFO entry with src==0 gets discard=1;
  - source-1 entries are untouched.
- Response routing, by FIFO head:
  - discard=1: `m_resp_ready_o`=1, `resp_valid_o`=00; the response is swallowed.
  - otherwise: `resp_valid_o[src]` = `m_resp_valid_i`, and `m_resp_ready_o` = `resp_ready_i[src]`.
  - `resp_o` = `m_resp_i`.
- Pop the FIFO on `m_resp_valid_i` & `m_resp_ready_o`.
- FIFO empty: `m_resp_ready_o`=0. A response arriving while empty fires an assertion.

## Timing
- Source accept at cycle t presents on `m_req_o` at t+1 earliest. Sustained throughput is 1 request per cycle.
- Response path is combinational, with 0 cycles of latency.
- `full` is computed from the registered count only. A pop in cycle t enables a push at t+1 at the earliest, so there is no combinational path from the response side to the request side.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo `MAX_OUTST`.
- Flush in the same cycle as a source-0 downstream handshake: the pushed entry has discard=1.
- Flush in the same cycle as a discard-head pop: the pop proceeds normally.
- `rst_n` low mid-transaction: all state is cleared the next edge. Outstanding responses are not tracked afterwards; the downstream is reset by the same signal.

## Structure
- `iq_lsu_req_t` and `iq_lsu_resp_t` stay in the shared `wired0` package. A new `lsu_src_e` (SRC_IQ=0, SRC_CMT=1) goes there too.
- One sub-module: `wired_lsu_outst_fifo`, an in-order {src, discard} FIFO with a broadcast "mark all src==0 as discard" port.
- Arbitration and the output register stay in the top module.

## Test plan
- Both sources valid continuously, `m_req_ready_i`=1: grants alternate 0,1,0,1. Responses returned in order reach `resp_valid_o` 01,10,01,10.
- `MAX_OUTST`=4 with 4 requests accepted and no responses: `m_req_valid_o`=0 while the 5th is held in the register. One response is popped and the 5th is issued the following cycle.
- Issue src0, src1, src0, then assert `flush_i`: the 1st and 3rd responses are swallowed (`m_resp_ready_o`=1, `resp_valid_o`=00), and the 2nd is delivered to source 1.
- Output register holds a src0 request with `m_req_ready_i`=0, then `flush_i` pulses: `m_req_valid_o`=0 next cycle and no FIFO push. A waiting source-1 request is loaded the next cycle.
- `resp_ready_i[1]`=0 with the head src=1: `m_resp_ready_o`=0 and the head stays. Releasing it pops one entry.
- `rst_n` low for 1 cycle with 3 outstanding: count=0, `m_req_valid_o`=0, `rr_q`=0.

Source files
------------

// File: rtl/wired0_pkg.sv
// ============================================================================
// Module  : wired0 (package)
// Brief   : Shared LSU request/response payloads and the LSU source enum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wired0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } iq_lsu_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } iq_lsu_resp_t;

  typedef enum logic {
    SRC_IQ  = 1'b0,
    SRC_CMT = 1'b1
  } lsu_src_e;

  function automatic lsu_src_e lsu_src_other(lsu_src_e s);
    return (s == SRC_IQ) ? SRC_CMT : SRC_IQ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wired_lsu_req_arb_if.sv
// ============================================================================
// Module  : wired_lsu_req_arb_if
// Brief   : Source-side and downstream-side handshakes of the LSU request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wired_lsu_req_arb_if;
  import wired0::*;

  logic               flush_i;
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  iq_lsu_req_t [1:0]  req_i;
  logic [1:0]         resp_valid_o;
  logic [1:0]         resp_ready_i;
  iq_lsu_resp_t       resp_o;
  logic               m_req_valid_o;
  logic               m_req_ready_i;
  iq_lsu_req_t        m_req_o;
  logic               m_resp_valid_i;
  logic               m_resp_ready_o;
  iq_lsu_resp_t       m_resp_i;

  modport slave (
    input  flush_i, req_valid_i, req_i, resp_ready_i,
           m_req_ready_i, m_resp_valid_i, m_resp_i,
    output req_ready_o, resp_valid_o, resp_o,
           m_req_valid_o, m_req_o, m_resp_ready_o
  );

  modport master (
    output flush_i, req_valid_i, req_i, resp_ready_i,
           m_req_ready_i, m_resp_valid_i, m_resp_i,
    input  req_ready_o, resp_valid_o, resp_o,
           m_req_valid_o, m_req_o, m_resp_ready_o
  );

endinterface

`default_nettype wire

// File: rtl/wired_lsu_outst_fifo.sv
// ============================================================================
// Module  : wired_lsu_outst_fifo
// Brief   : In-order {src, discard} tracker for outstanding downstream requests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wired_lsu_outst_fifo
  import wired0::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  lsu_src_e push_src,
  input  logic     push_discard,
  input  logic     pop,
  input  logic     mark_discard,
  output lsu_src_e head_src,
  output logic     head_discard,
  output logic     empty,
  output logic     full
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [DEPTH-1:0]   r_src;
  logic [DEPTH-1:0]   r_discard;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_ptr_w:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src     <= '0;
      r_discard <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      // Stale slots may be marked too; a later push rewrites both fields.
      if (mark_discard) r_discard <= r_discard | ~r_src;
      if (push) begin
        r_src[r_tail]     <= push_src;
        r_discard[r_tail] <= push_discard;
        r_tail            <= r_tail + 1'b1;
      end
      if (pop) r_head <= r_head + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_src     = lsu_src_e'(r_src[r_head]);
  assign head_discard = r_discard[r_head];
  assign empty        = (r_count == '0);
  assign full         = (r_count == c_full);

endmodule

`default_nettype wire

// File: rtl/wired_lsu_req_arb.sv
// ============================================================================
// Module  : wired_lsu_req_arb
// Brief   : Round-robin share of the D-cache port between the LSU issue queue
//           and the commit path, with in-order response routing and flush drop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wired_lsu_req_arb
  import wired0::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wired_lsu_req_arb_if.slave  bus
);

  logic        r_out_valid;
  lsu_src_e    r_out_src;
  iq_lsu_req_t r_out_req;
  lsu_src_e    r_rr;

  logic        w_full;
  logic        w_empty;
  lsu_src_e    w_head_src;
  logic        w_head_discard;
  logic        w_m_fire;
  logic        w_ld;
  logic [1:0]  w_elig;
  logic [1:0]  w_req_ready;
  logic [1:0]  w_hs;
  lsu_src_e    w_gnt_src;
  logic [1:0]  w_resp_valid;
  logic        w_m_resp_ready;
  logic        w_pop;

  // Full uses the registered count only, keeping responses off the request path.
  assign bus.m_req_valid_o = r_out_valid & ~w_full;
  assign bus.m_req_o       = r_out_req;
  assign w_m_fire          = r_out_valid & ~w_full & bus.m_req_ready_i;
  assign w_ld              = ~r_out_valid | w_m_fire;

  assign w_elig         = {bus.req_valid_i[1], bus.req_valid_i[0] & ~bus.flush_i};
  assign w_req_ready[0] = w_ld & ~bus.flush_i & (~w_elig[1] | (r_rr == SRC_IQ));
  assign w_req_ready[1] = w_ld & (~w_elig[0] | (r_rr == SRC_CMT));
  assign w_hs           = bus.req_valid_i & w_req_ready;
  assign w_gnt_src      = w_hs[1] ? SRC_CMT : SRC_IQ;
  assign bus.req_ready_o = w_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_src   <= SRC_IQ;
      r_out_req   <= '0;
      r_rr        <= SRC_IQ;
    end else if (w_ld) begin
      if (|w_hs) begin
        r_out_valid <= 1'b1;
        r_out_src   <= w_gnt_src;
        r_out_req   <= w_hs[1] ? bus.req_i[1] : bus.req_i[0];
        r_rr        <= lsu_src_other(w_gnt_src);
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (bus.flush_i && (r_out_src == SRC_IQ)) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    w_resp_valid   = 2'b00;
    w_m_resp_ready = 1'b0;
    if (!w_empty) begin
      if (w_head_discard) begin
        w_m_resp_ready = 1'b1;
      end else if (w_head_src == SRC_CMT) begin
        w_resp_valid[1] = bus.m_resp_valid_i;
        w_m_resp_ready  = bus.resp_ready_i[1];
      end else begin
        w_resp_valid[0] = bus.m_resp_valid_i;
        w_m_resp_ready  = bus.resp_ready_i[0];
      end
    end
  end

  assign bus.resp_valid_o   = w_resp_valid;
  assign bus.m_resp_ready_o = w_m_resp_ready;
  assign bus.resp_o         = bus.m_resp_i;
  assign w_pop              = bus.m_resp_valid_i & w_m_resp_ready;

  wired_lsu_outst_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_outst_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (w_m_fire),
    .push_src     (r_out_src),
    .push_discard (bus.flush_i & (r_out_src == SRC_IQ)),
    .pop          (w_pop),
    .mark_discard (bus.flush_i),
    .head_src     (w_head_src),
    .head_discard (w_head_discard),
    .empty        (w_empty),
    .full         (w_full)
  );

  a_no_resp_when_empty : assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.m_resp_valid_i && w_empty)
  );

endmodule

`default_nettype wire
